// File: rtl/sig_timing_mon.sv
// Pulse-width and period monitor for one asynchronous input, measured in clk cycles.
// Optional macro SIG_MON_GLITCH_FILTER_EN adds a 2-cycle stability filter after the synchroniser.
module sig_timing_mon #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             i_sig_in,
    input  logic             i_en,
    input  logic [CNT_W-1:0] i_min_width,
    input  logic [CNT_W-1:0] i_min_period,
    input  logic [CNT_W-1:0] i_max_period,
    input  logic             i_clr_sticky,
    output logic             o_width_vld,
    output logic             o_period_vld,
    output logic [CNT_W-1:0] o_last_width,
    output logic [CNT_W-1:0] o_last_period,
    output logic             o_width_err,
    output logic             o_period_err,
    output logic [1:0]       o_err_sticky
);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        HIGH,
        LOW
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t             r_state;
    state_t             w_stateNxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic               w_syncOut;
    logic               w_s;
    logic               r_sD;
    logic               w_rise;
    logic               w_fall;
    logic [CNT_W-1:0]   r_wCnt;
    logic [CNT_W-1:0]   r_pCnt;
    logic               r_toDone;
    logic [CNT_W:0]     w_toLimit;
    logic               w_timeout;
    logic               w_widthCap;
    logic               w_periodCap;
    logic               w_widthErrNxt;
    logic               w_periodErrNxt;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_sig_in};
        end
    end

    assign w_syncOut = r_sync[SYNC_STAGES-1];

`ifdef SIG_MON_GLITCH_FILTER_EN
    logic r_syncD;
    logic r_filt;

    // The filtered level follows the synchronised input only once it has been stable for two samples.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_syncD <= 1'b0;
            r_filt  <= 1'b0;
        end else begin
            r_syncD <= w_syncOut;
            if (w_syncOut == r_syncD) begin
                r_filt <= w_syncOut;
            end
        end
    end

    assign w_s = r_filt;
`else
    assign w_s = w_syncOut;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_sD <= 1'b0;
        end else begin
            r_sD <= w_s;
        end
    end

    assign w_rise = w_s & ~r_sD;
    assign w_fall = ~w_s & r_sD;

    // Counters freeze while disabled so the last partial measurement is never resumed mid-way.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_wCnt   <= '0;
            r_pCnt   <= '0;
            r_toDone <= 1'b0;
        end else if (i_en) begin
            if (w_rise) begin
                r_wCnt <= CNT_ONE;
            end else if (w_s && (r_wCnt != CNT_MAX)) begin
                r_wCnt <= r_wCnt + CNT_ONE;
            end
            if (w_rise) begin
                r_pCnt <= CNT_ONE;
            end else if (r_pCnt != CNT_MAX) begin
                r_pCnt <= r_pCnt + CNT_ONE;
            end
            if (w_rise) begin
                r_toDone <= 1'b0;
            end else if (w_timeout) begin
                r_toDone <= 1'b1;
            end
        end
    end

    // One bit wider so an all-ones max_period can never be matched.
    assign w_toLimit = {1'b0, i_max_period} + {{CNT_W{1'b0}}, 1'b1};
    assign w_timeout = ((r_state == HIGH) || (r_state == LOW)) && !r_toDone
                       && ({1'b0, r_pCnt} == w_toLimit);

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNxt;
        end
    end

    always_comb begin
        w_stateNxt     = r_state;
        w_widthCap     = 1'b0;
        w_periodCap    = 1'b0;
        w_widthErrNxt  = 1'b0;
        w_periodErrNxt = 1'b0;
        if (!i_en) begin
            w_stateNxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    w_stateNxt = ARMED;
                end
                ARMED: begin
                    if (w_rise) begin
                        w_stateNxt = HIGH;
                    end
                end
                HIGH: begin
                    if (w_fall) begin
                        w_stateNxt    = LOW;
                        w_widthCap    = 1'b1;
                        w_widthErrNxt = (r_wCnt < i_min_width);
                    end
                    if (w_timeout) begin
                        w_periodErrNxt = 1'b1;
                    end
                end
                LOW: begin
                    if (w_rise) begin
                        w_stateNxt     = HIGH;
                        w_periodCap    = 1'b1;
                        w_periodErrNxt = (r_pCnt < i_min_period) || (r_pCnt > i_max_period);
                    end
                    if (w_timeout) begin
                        w_periodErrNxt = 1'b1;
                    end
                end
                default: begin
                    w_stateNxt = IDLE;
                end
            endcase
        end
    end

    // A new error outranks a simultaneous clear of its sticky bit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            o_width_vld   <= 1'b0;
            o_period_vld  <= 1'b0;
            o_width_err   <= 1'b0;
            o_period_err  <= 1'b0;
            o_last_width  <= '0;
            o_last_period <= '0;
            o_err_sticky  <= 2'b00;
        end else begin
            o_width_vld  <= w_widthCap;
            o_period_vld <= w_periodCap;
            o_width_err  <= w_widthErrNxt;
            o_period_err <= w_periodErrNxt;
            if (w_widthCap) begin
                o_last_width <= r_wCnt;
            end
            if (w_periodCap) begin
                o_last_period <= r_pCnt;
            end
            o_err_sticky[0] <= w_widthErrNxt  | (o_err_sticky[0] & ~i_clr_sticky);
            o_err_sticky[1] <= w_periodErrNxt | (o_err_sticky[1] & ~i_clr_sticky);
        end
    end

endmodule
